// File: rtl/audio_pkg.sv
// Shared constants and helpers for the receive-side audio demultiplexer.
package audio_pkg;

    localparam int WIN_LEN   = 5000;
    localparam int WIN_RECIP = 3355;
    localparam int ACC1_W    = 25;
    localparam int ACC2_W    = 26;
    localparam int FRAC_W    = 24;
    // Rounded window average, wide enough to hold the unsigned envelope (<= 4096).
    localparam int AVG_W     = 14;

    function automatic logic signed [11:0] sat12(input logic signed [15:0] v);
        if (v > 16'sd2047)
            return 12'sh7ff;
        else if (v < -16'sd2048)
            return 12'sh800;
        else
            return v[11:0];
    endfunction

endpackage

// File: rtl/window_avg.sv
// Integrate-and-dump over a window closed by an external pulse, then scale by
// the window reciprocal and round to nearest.
module window_avg
    import audio_pkg::*;
#(
    parameter bit SIGNED = 1'b1,
    parameter int IN_W   = 12,
    parameter int ACC_W  = ACC1_W,
    parameter int RECIP  = WIN_RECIP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_wend,
    input  logic [IN_W-1:0]  i_x,
    output logic [AVG_W-1:0] o_avg
);

    localparam int PROD_W = AVG_W + FRAC_W;

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_dump;
    logic [PROD_W-1:0] r_prod;

    logic [ACC_W-1:0]  w_x_ext;
    logic [ACC_W-1:0]  w_sum;
    logic [PROD_W-1:0] w_dump_ext;
    logic [PROD_W-1:0] w_prod;

    assign w_x_ext    = {{(ACC_W-IN_W){SIGNED & i_x[IN_W-1]}}, i_x};
    assign w_sum      = r_acc + w_x_ext;
    // Operands are extended to the full product width, so the low PROD_W bits
    // of the product are exact for both signed and unsigned data.
    assign w_dump_ext = {{(PROD_W-ACC_W){SIGNED & r_dump[ACC_W-1]}}, r_dump};
    assign w_prod     = w_dump_ext * PROD_W'(RECIP);
    assign o_avg      = AVG_W'((r_prod + (PROD_W'(1) << (FRAC_W-1))) >> FRAC_W);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_dump <= '0;
            r_prod <= '0;
        end else begin
            if (i_en)
                r_acc <= i_wend ? '0 : w_sum;
            if (i_wend)
                r_dump <= w_sum;
            r_prod <= w_prod;
        end
    end

endmodule

// File: rtl/audio_demux.sv
// Recovers CH1 (window mean) and CH2 (envelope of the residual minus tracked DC)
// from the FM-demodulated composite, one output pair per subcarrier period.
module audio_demux
    import audio_pkg::*;
#(
    parameter int INPUT_WIDTH    = 12,
    parameter int OUTPUT_WIDTH   = 12,
    parameter int WIN_LEN        = audio_pkg::WIN_LEN,
    parameter int WIN_RECIP      = audio_pkg::WIN_RECIP,
    parameter int DC_SHIFT       = 6,
    parameter int CH2_GAIN_SHIFT = 1
) (
    input  logic                    clk_in,
    input  logic                    RST,
    input  logic [INPUT_WIDTH-1:0]  Module_SIG,
    input  logic                    sig_valid,
    output logic [OUTPUT_WIDTH-1:0] Audio_CH1,
    output logic [OUTPUT_WIDTH-1:0] Audio_CH2,
    output logic                    audio_valid,
    output logic                    clip
);

    localparam int CNT_W = $clog2(WIN_LEN);

    localparam logic [1:0] ST_COLD   = 2'd0;
    localparam logic [1:0] ST_PRIMED = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_vld_pipe;
    logic [1:0]         r_state;
    logic [11:0]        r_ch1_est;
    logic [AVG_W-1:0]   r_e;
    logic [AVG_W+7:0]   r_dc;

    logic               w_wend;
    logic [12:0]        w_r;
    logic [12:0]        w_abs;
    logic [AVG_W-1:0]   w_avg1;
    logic [AVG_W-1:0]   w_avg2;
    logic [AVG_W+7:0]   w_e_q8;
    logic signed [22:0] w_dc_diff;
    logic signed [22:0] w_dc_step;
    logic [AVG_W+7:0]   w_dc_next;
    logic signed [15:0] w_ch2_diff;
    logic signed [15:0] w_ch2_dev;
    logic signed [11:0] w_ch2_sat;
    logic               w_ch2_clip;

    assign w_wend = sig_valid && (r_cnt == CNT_W'(WIN_LEN-1));
    assign w_r    = {Module_SIG[INPUT_WIDTH-1], Module_SIG} - {r_ch1_est[11], r_ch1_est};
    assign w_abs  = w_r[12] ? (13'd0 - w_r) : w_r;

    window_avg #(
        .SIGNED (1'b1),
        .IN_W   (INPUT_WIDTH),
        .ACC_W  (ACC1_W),
        .RECIP  (WIN_RECIP)
    ) u_ch1_avg (
        .i_clk   (clk_in),
        .i_rst_n (RST),
        .i_en    (sig_valid),
        .i_wend  (w_wend),
        .i_x     (Module_SIG),
        .o_avg   (w_avg1)
    );

    window_avg #(
        .SIGNED (1'b0),
        .IN_W   (13),
        .ACC_W  (ACC2_W),
        .RECIP  (WIN_RECIP)
    ) u_env_avg (
        .i_clk   (clk_in),
        .i_rst_n (RST),
        .i_en    (sig_valid),
        .i_wend  (w_wend),
        .i_x     (w_abs),
        .o_avg   (w_avg2)
    );

    // The first tracked window seeds dc with the envelope itself, so CH2 starts at 0.
    assign w_e_q8     = {r_e, 8'd0};
    assign w_dc_diff  = $signed({1'b0, w_e_q8}) - $signed({1'b0, r_dc});
    assign w_dc_step  = w_dc_diff >>> DC_SHIFT;
    assign w_dc_next  = (r_state == ST_PRIMED) ? w_e_q8
                                               : 22'($signed({1'b0, r_dc}) + w_dc_step);
    assign w_ch2_diff = $signed({2'b00, r_e}) - $signed({2'b00, w_dc_next[AVG_W+7:8]});
    assign w_ch2_dev  = w_ch2_diff <<< CH2_GAIN_SHIFT;
    assign w_ch2_sat  = sat12(w_ch2_dev);
    assign w_ch2_clip = (w_ch2_dev > 16'sd2047) || (w_ch2_dev < -16'sd2048);

    always_ff @(posedge clk_in) begin
        if (!RST) begin
            r_cnt       <= '0;
            r_vld_pipe  <= '0;
            r_state     <= ST_COLD;
            r_ch1_est   <= '0;
            r_e         <= '0;
            r_dc        <= '0;
            Audio_CH1   <= '0;
            Audio_CH2   <= '0;
            audio_valid <= 1'b0;
            clip        <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            r_vld_pipe  <= {r_vld_pipe[1:0], w_wend};
            if (sig_valid)
                r_cnt <= w_wend ? '0 : r_cnt + 1'b1;
            if (r_vld_pipe[1]) begin
                r_ch1_est <= sat12({{2{w_avg1[AVG_W-1]}}, w_avg1});
                r_e       <= w_avg2;
            end
            // The first window only establishes ch1_est; nothing is emitted for it.
            if (r_vld_pipe[2]) begin
                case (r_state)
                    ST_COLD: r_state <= ST_PRIMED;
                    default: begin
                        r_state     <= ST_RUN;
                        r_dc        <= w_dc_next;
                        Audio_CH1   <= r_ch1_est;
                        Audio_CH2   <= w_ch2_sat;
                        audio_valid <= 1'b1;
                        if (w_ch2_clip)
                            clip <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_demux.sv
// Scoreboard bench for audio_demux: window-level reference model feeds an
// expectation queue that a negedge monitor drains on every audio_valid.
module tb_audio_demux;

    logic        clk_in;
    logic        RST;
    logic [11:0] Module_SIG;
    logic        sig_valid;
    logic [11:0] Audio_CH1;
    logic [11:0] Audio_CH2;
    logic        audio_valid;
    logic        clip;

    audio_demux dut (
        .clk_in      (clk_in),
        .RST         (RST),
        .Module_SIG  (Module_SIG),
        .sig_valid   (sig_valid),
        .Audio_CH1   (Audio_CH1),
        .Audio_CH2   (Audio_CH2),
        .audio_valid (audio_valid),
        .clip        (clip)
    );

    typedef struct {
        int due;
        int ch1;
        int ch2;
        int clp;
    } exp_t;

    exp_t sbq[$];
    exp_t ex;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;
    int   ecount  = 0;

    // Reference model state: window sums and the estimate schedule.
    int     m_cnt;
    longint m_sum1, m_sum2;
    int     m_est, m_pend_val, m_pend_edge;
    bit     m_pend;
    int     m_windows;
    int     m_dc;
    int     m_clip;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) edge_n <= edge_n + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: run exceeded time limit, edge=%0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp_v, edge_n);
        end
    endtask

    always @(negedge clk_in) begin
        if (audio_valid) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got audio_valid, expected none (edge %0d)", edge_n);
            end else begin
                ex = sbq.pop_front();
                chk("strobe_edge", edge_n, ex.due);
                chk("ch1", int'($signed(Audio_CH1)), ex.ch1);
                chk("ch2", int'($signed(Audio_CH2)), ex.ch2);
                chk("clip", int'(clip), ex.clp);
            end
        end
    end

    function automatic int sat12i(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_sum1 = 0; m_sum2 = 0;
        m_est = 0; m_pend = 0; m_pend_val = 0; m_pend_edge = 0;
        m_windows = 0; m_dc = 0; m_clip = 0;
        sbq.delete();
    endtask

    // One accepted window: averages, estimate hand-off two edges later, outputs three later.
    task automatic model_window(input int e);
        int a1, env, dcn, ch2;
        a1  = sat12i(int'((m_sum1 * 3355 + 64'sd8388608) >>> 24));
        env = int'((m_sum2 * 3355 + 64'sd8388608) >>> 24);
        m_pend = 1; m_pend_val = a1; m_pend_edge = e + 2;
        if (m_windows >= 1) begin
            dcn = (m_windows == 1) ? env * 256 : m_dc + ((env * 256 - m_dc) >>> 6);
            m_dc = dcn;
            ch2 = (env - (dcn >>> 8)) * 2;
            if (ch2 != sat12i(ch2)) m_clip = 1;
            sbq.push_back('{due: e + 3, ch1: a1, ch2: sat12i(ch2), clp: m_clip});
        end
        m_windows++;
        m_sum1 = 0; m_sum2 = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit rst_n, input bit v, input int x);
        int r;
        if (!rst_n) begin
            model_reset();
        end else if (v) begin
            if (m_pend && ecount > m_pend_edge) begin
                m_est = m_pend_val;
                m_pend = 0;
            end
            r = x - m_est;
            m_sum1 += x;
            m_sum2 += (r < 0) ? -r : r;
            m_cnt++;
            if (m_cnt == 5000) model_window(ecount);
        end
    endtask

    task automatic drive(input bit rst_n, input bit v, input int x);
        logic signed [11:0] xv;
        xv = 12'(x);
        RST = rst_n; sig_valid = v; Module_SIG = xv;
        @(posedge clk_in);
        #1;
        ecount++;
        model_edge(rst_n, v, int'(xv));
    endtask

    task automatic chk_reset();
        chk("rst_ch1", int'($signed(Audio_CH1)), 0);
        chk("rst_ch2", int'($signed(Audio_CH2)), 0);
        chk("rst_valid", int'(audio_valid), 0);
        chk("rst_clip", int'(clip), 0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 0);
        chk_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, int'($urandom_range(4095)) - 2048);
    endtask

    function automatic int sine_x(input int k, input int amp);
        real ph;
        ph = 6.283185307179586 * real'(k) / 5000.0;
        return int'(real'(amp) * $sin(ph));
    endfunction

    initial begin
        RST = 1'b0; sig_valid = 1'b0; Module_SIG = '0;
        model_reset();
        do_reset();
        do_reset();

        // Constant 100, interrupted by a reset mid-window.
        for (int i = 0; i < 2500; i++) drive(1'b1, 1'b1, 100);
        do_reset();
        for (int i = 0; i < 15000; i++) drive(1'b1, 1'b1, 100);
        idle(8);

        // Noisy sine, amplitude step 1000 -> 1500 on a window boundary.
        do_reset();
        for (int k = 0; k < 20000; k++)
            drive(1'b1, 1'b1, sine_x(k, (k < 15000) ? 1000 : 1500) + int'($urandom_range(6)) - 3);
        idle(8);

        // Large envelope step drives CH2 into saturation; clip must stay up.
        do_reset();
        for (int k = 0; k < 15000; k++)
            drive(1'b1, 1'b1, sine_x(k, (k < 10000) ? 200 : 2000));
        idle(8);
        chk("clip_sticky", int'(clip), m_clip);

        // Full-scale negative constant.
        do_reset();
        for (int i = 0; i < 10000; i++) drive(1'b1, 1'b1, -2048);
        idle(8);

        // Alternating qualifier; garbage on the unqualified cycles must be ignored.
        do_reset();
        for (int k = 0; k < 20000; k++) begin
            if (k % 2 == 0) drive(1'b1, 1'b1, 100);
            else            drive(1'b1, 1'b0, int'($urandom_range(4095)) - 2048);
        end
        idle(8);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
